// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite response codes and the writer FSM state encoding.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ISSUE   = 2'b01,
        WAIT_B  = 2'b10,
        BACKOFF = 2'b11
    } wr_state_t;

    function automatic logic resp_is_okay(input logic [1:0] resp);
        return (resp == RESP_OKAY);
    endfunction

endpackage

// File: rtl/axi_lite_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with a registered head stage and occupancy output.
module axi_lite_sync_fifo
    import axi_lite_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int LW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             head_valid,
    output logic             full,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [LW-1:0]    mem_cnt_r;
    logic [LW-1:0]    level_r;
    logic [WIDTH-1:0] out_data_r;
    logic             out_valid_r;
    logic             pop_s;
    logic             push_s;
    logic             load_s;
    logic             full_s;

    // Qualify requests; the head register refills whenever it is free or being consumed.
    always_comb begin
        full_s = (level_r == LW'(DEPTH));
        pop_s  = pop && out_valid_r;
        push_s = push && (!full_s || pop_s);
        load_s = (mem_cnt_r != {LW{1'b0}}) && (!out_valid_r || pop_s);
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers, counts and the head register.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r    <= {PW{1'b0}};
            rd_ptr_r    <= {PW{1'b0}};
            mem_cnt_r   <= {LW{1'b0}};
            level_r     <= {LW{1'b0}};
            out_data_r  <= {WIDTH{1'b0}};
            out_valid_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (load_s) begin
                rd_ptr_r    <= rd_ptr_r + PW'(1);
                out_data_r  <= mem_r[rd_ptr_r];
                out_valid_r <= 1'b1;
            end else if (pop_s) begin
                out_valid_r <= 1'b0;
            end
            mem_cnt_r <= mem_cnt_r + LW'(push_s) - LW'(load_s);
            level_r   <= level_r + LW'(push_s) - LW'(pop_s);
        end
    end

    assign head_data  = out_data_r;
    assign head_valid = out_valid_r;
    assign full       = full_s;
    assign level      = level_r;

endmodule

// File: rtl/axi_lite_fifo_writer.sv
// AXI4-Lite write-only master: buffers producer words and issues one AW+W write per word,
// retrying SLVERR responses after a backoff and dropping the word once retries run out.
module axi_lite_fifo_writer
    import axi_lite_pkg::*;
#(
    parameter int                    ADDR_WIDTH     = 4,
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    SRC_FIFO_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] WR_ADDR        = {ADDR_WIDTH{1'b0}},
    parameter int                    MAX_RETRY      = 3,
    parameter int                    BACKOFF_CYC    = 8,
    localparam int LW = $clog2(SRC_FIFO_DEPTH) + 1,
    localparam int SW = DATA_WIDTH / 8
) (
    input  logic                  clk_axi,
    input  logic                  axi_reset_i,
    input  logic                  src_valid_i,
    input  logic [DATA_WIDTH-1:0] src_data_i,
    output logic                  src_ready_o,
    output logic [ADDR_WIDTH-1:0] axi_awaddr_o,
    output logic                  axi_awvalid_o,
    input  logic                  axi_awready_i,
    output logic [DATA_WIDTH-1:0] axi_wdata_o,
    output logic [SW-1:0]         axi_wstrb_o,
    output logic                  axi_wvalid_o,
    input  logic                  axi_wready_i,
    input  logic [1:0]            axi_bresp_i,
    input  logic                  axi_bvalid_i,
    output logic                  axi_bready_o,
    output logic                  wr_busy_o,
    output logic                  wr_drop_o,
    output logic [15:0]           wr_ok_cnt_o,
    output logic [LW-1:0]         wr_level_o
);

    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam int BW = (BACKOFF_CYC < 2) ? 1 : $clog2(BACKOFF_CYC);

    wr_state_t             state_r;
    logic                  awvalid_r;
    logic                  wvalid_r;
    logic                  bready_r;
    logic                  drop_r;
    logic [DATA_WIDTH-1:0] wdata_r;
    logic [15:0]           ok_cnt_r;
    logic [RW-1:0]         retry_r;
    logic [BW-1:0]         backoff_r;

    logic [DATA_WIDTH-1:0] head_data_s;
    logic                  head_valid_s;
    logic                  full_s;
    logic [LW-1:0]         level_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  b_hs_s;
    logic                  resp_ok_s;
    logic                  retry_left_s;
    logic                  aw_fin_s;
    logic                  w_fin_s;

    axi_lite_sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (SRC_FIFO_DEPTH)
    ) u_src_fifo (
        .clk        (clk_axi),
        .rst        (axi_reset_i),
        .push       (push_s),
        .push_data  (src_data_i),
        .pop        (pop_s),
        .head_data  (head_data_s),
        .head_valid (head_valid_s),
        .full       (full_s),
        .level      (level_s)
    );

    // The head word leaves the buffer only on OKAY or when it is finally dropped.
    always_comb begin
        push_s       = src_valid_i && !full_s;
        b_hs_s       = (state_r == WAIT_B) && axi_bvalid_i && bready_r;
        resp_ok_s    = resp_is_okay(axi_bresp_i);
        retry_left_s = (retry_r < RW'(MAX_RETRY));
        aw_fin_s     = !awvalid_r || axi_awready_i;
        w_fin_s      = !wvalid_r || axi_wready_i;
        if (b_hs_s && (resp_ok_s || !retry_left_s)) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
    end

    // Writer FSM with registered AXI outputs and retry/backoff bookkeeping.
    always_ff @(posedge clk_axi) begin
        if (axi_reset_i) begin
            state_r   <= IDLE;
            awvalid_r <= 1'b0;
            wvalid_r  <= 1'b0;
            bready_r  <= 1'b0;
            drop_r    <= 1'b0;
            wdata_r   <= {DATA_WIDTH{1'b0}};
            ok_cnt_r  <= 16'd0;
            retry_r   <= {RW{1'b0}};
            backoff_r <= {BW{1'b0}};
        end else begin
            drop_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (head_valid_s) begin
                        state_r   <= ISSUE;
                        awvalid_r <= 1'b1;
                        wvalid_r  <= 1'b1;
                        wdata_r   <= head_data_s;
                        retry_r   <= {RW{1'b0}};
                    end
                end
                ISSUE: begin
                    if (awvalid_r && axi_awready_i) begin
                        awvalid_r <= 1'b0;
                    end
                    if (wvalid_r && axi_wready_i) begin
                        wvalid_r <= 1'b0;
                    end
                    if (aw_fin_s && w_fin_s) begin
                        state_r  <= WAIT_B;
                        bready_r <= 1'b1;
                    end
                end
                WAIT_B: begin
                    if (b_hs_s) begin
                        bready_r <= 1'b0;
                        if (resp_ok_s) begin
                            ok_cnt_r <= ok_cnt_r + 16'd1;
                            state_r  <= IDLE;
                        end else if (retry_left_s) begin
                            retry_r   <= retry_r + RW'(1);
                            backoff_r <= {BW{1'b0}};
                            state_r   <= BACKOFF;
                        end else begin
                            drop_r  <= 1'b1;
                            state_r <= IDLE;
                        end
                    end
                end
                BACKOFF: begin
                    // The head word is still buffered, so the reissue re-reads it.
                    if (backoff_r == BW'(BACKOFF_CYC - 1)) begin
                        state_r   <= ISSUE;
                        awvalid_r <= 1'b1;
                        wvalid_r  <= 1'b1;
                        wdata_r   <= head_data_s;
                        backoff_r <= {BW{1'b0}};
                    end else begin
                        backoff_r <= backoff_r + BW'(1);
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    awvalid_r <= 1'b0;
                    wvalid_r  <= 1'b0;
                    bready_r  <= 1'b0;
                end
            endcase
        end
    end

    assign src_ready_o   = !full_s;
    assign axi_awaddr_o  = WR_ADDR;
    assign axi_awvalid_o = awvalid_r;
    assign axi_wdata_o   = wdata_r;
    assign axi_wstrb_o   = {SW{1'b1}};
    assign axi_wvalid_o  = wvalid_r;
    assign axi_bready_o  = bready_r;
    assign wr_busy_o     = (state_r != IDLE) || (level_s != {LW{1'b0}});
    assign wr_drop_o     = drop_r;
    assign wr_ok_cnt_o   = ok_cnt_r;
    assign wr_level_o    = level_s;

endmodule
